// File: rtl/vga_sync_receiver_if.sv
// Sync inputs and recovered timing outputs shared by the VGA pin driver and the
// sync receiver.
interface vga_sync_receiver_if;
    logic       hSync;
    logic       vSync;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       activeVideo;
    logic       frameStart;
    logic       locked;
    logic [7:0] errCount;

    modport master (
        output hSync, vSync,
        input  hCount, vCount, activeVideo, frameStart, locked, errCount
    );

    modport slave (
        input  hSync, vSync,
        output hCount, vCount, activeVideo, frameStart, locked, errCount
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// Rebuilds pixel/line position from the VGA sync pair and checks it against the
// expected mode timing. Lock status and a saturating lock-loss count are reported.
module vga_sync_receiver #(
    parameter int PIX_SHIFT = 2,
    parameter int H_TOTAL   = 800,
    parameter int H_SYNC    = 96,
    parameter int H_ACT     = 144,
    parameter int V_TOTAL   = 525,
    parameter int V_SYNC    = 2,
    parameter int V_ACT     = 35,
    parameter int H_WIDTH   = 640,
    parameter int V_HEIGHT  = 480
) (
    input  logic                Clk,
    input  logic                Reset,
    vga_sync_receiver_if.slave  vga
);

    localparam logic [12:0] LINE_CLKS   = 13'(H_TOTAL << PIX_SHIFT);
    localparam logic [12:0] SYNC_CLKS   = 13'(H_SYNC << PIX_SHIFT);
    localparam logic [10:0] FRAME_LINES = 11'(V_TOTAL);
    localparam logic [10:0] SYNC_LINES  = 11'(V_SYNC);
    localparam logic [9:0]  H_FIRST     = 10'(H_ACT);
    localparam logic [9:0]  H_LAST      = 10'(H_ACT + H_WIDTH);
    localparam logic [9:0]  V_FIRST     = 10'(V_ACT);
    localparam logic [9:0]  V_LAST      = 10'(V_ACT + V_HEIGHT);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    function automatic logic [11:0] satInc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic        hq1, hq2, vq1, vq2;
    logic        hFall, hRise, vFall, vRise;
    logic [11:0] lineClk;
    logic [9:0]  lineCnt;
    logic        satSeen;
    logic        vFall_p1;
    logic [12:0] lineClkInc;
    logic [10:0] lineCntInc;
    logic [9:0]  pixIdx;
    logic        inWindow;
    logic        timeoutErr, lineErr, frameErr, anyErr;
    logic        errSeen;
    state_t      state;

    logic [9:0]  hCountR, vCountR;
    logic        activeR, frameStartR, lockedR;
    logic [7:0]  errCountR;

    assign hFall = hq2 & ~hq1;
    assign hRise = ~hq2 & hq1;
    assign vFall = vq2 & ~vq1;
    assign vRise = ~vq2 & vq1;

    // Compare in one extra bit so a saturated lineClk cannot wrap to a match.
    assign lineClkInc = {1'b0, lineClk} + 13'd1;
    assign lineCntInc = {1'b0, lineCnt} + 11'd1;
    assign pixIdx     = 10'(lineClk >> PIX_SHIFT);
    assign inWindow   = (pixIdx >= H_FIRST) && (pixIdx < H_LAST) &&
                        (lineCnt >= V_FIRST) && (lineCnt < V_LAST);

    // satSeen marks that lineClk already sat at its ceiling, so a stuck hSync errs once.
    assign timeoutErr = (lineClk == 12'hFFF) && !satSeen;
    assign lineErr    = (hFall && (lineClkInc != LINE_CLKS)) ||
                        (hRise && (lineClkInc != SYNC_CLKS)) ||
                        timeoutErr;
    assign frameErr   = (vFall && (!hFall || (lineCntInc != FRAME_LINES))) ||
                        (vRise && (!hFall || (lineCntInc != SYNC_LINES)));
    assign anyErr     = lineErr || frameErr;

    // Stage p0: sync capture, position counters and the registered position outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hq1         <= 1'b1;
            hq2         <= 1'b1;
            vq1         <= 1'b1;
            vq2         <= 1'b1;
            lineClk     <= '0;
            lineCnt     <= '0;
            satSeen     <= 1'b0;
            vFall_p1    <= 1'b0;
            hCountR     <= '0;
            vCountR     <= '0;
            activeR     <= 1'b0;
            frameStartR <= 1'b0;
        end else begin
            hq1      <= vga.hSync;
            hq2      <= hq1;
            vq1      <= vga.vSync;
            vq2      <= vq1;
            satSeen  <= (lineClk == 12'hFFF);
            lineClk  <= hFall ? 12'd0 : satInc12(lineClk);
            if (hFall) begin
                lineCnt <= vFall ? 10'd0 : lineCntInc[9:0];
            end
            vFall_p1    <= vFall;
            hCountR     <= pixIdx;
            vCountR     <= lineCnt;
            activeR     <= inWindow;
            frameStartR <= vFall_p1;
        end
    end

    // Stage p1: lock FSM; an error in the vFall cycle still belongs to the frame that is ending.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= SEARCH;
            errSeen   <= 1'b0;
            lockedR   <= 1'b0;
            errCountR <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (vFall) state <= ACQUIRE;
                end
                ACQUIRE: begin
                    if (vFall && !(errSeen || anyErr)) state <= LOCKED;
                end
                LOCKED: begin
                    if (anyErr) begin
                        state     <= SEARCH;
                        errCountR <= satInc8(errCountR);
                    end
                end
                default: state <= SEARCH;
            endcase
            errSeen <= vFall ? 1'b0 : (errSeen || anyErr);
            lockedR <= (state == LOCKED) && !anyErr;
        end
    end

    assign vga.hCount      = hCountR;
    assign vga.vCount      = vCountR;
    assign vga.activeVideo = activeR;
    assign vga.frameStart  = frameStartR;
    assign vga.locked      = lockedR;
    assign vga.errCount    = errCountR;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a shrunken video mode so that many
// frames fit in a short run.
module tb_vga_sync_receiver;

    localparam int PS    = 1;
    localparam int HT    = 8;
    localparam int HS    = 2;
    localparam int HA    = 3;
    localparam int HW    = 4;
    localparam int VT    = 5;
    localparam int VS    = 2;
    localparam int VA    = 2;
    localparam int VH    = 2;
    localparam int LINE  = HT << PS;
    localparam int FRAME = LINE * VT;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    vga_sync_receiver_if vif ();

    vga_sync_receiver #(
        .PIX_SHIFT(PS), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT(VA), .H_WIDTH(HW), .V_HEIGHT(VH)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .vga   (vif.slave)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    int   tests = 0;
    int   fails = 0;
    int   lineStartCyc [0:VT-1];
    int   lockRiseCyc = -1;
    int   lockFallCyc = -1;
    int   fsCount = 0;
    int   fsLast = 0;
    int   fsInterval = 0;
    int   actAcc = 0;
    int   lastAct = 0;
    logic lockedPrev = 1'b0;
    logic [9:0] hHist [0:1023];
    logic [9:0] vHist [0:1023];
    logic       avHist [0:1023];

    // Event recorder: lock edges, frame pulses and per-frame active-video cycles.
    always @(negedge Clk) begin
        if (vif.locked === 1'b1 && lockedPrev === 1'b0) lockRiseCyc = cyc;
        if (vif.locked === 1'b0 && lockedPrev === 1'b1) lockFallCyc = cyc;
        lockedPrev = vif.locked;
        if (vif.frameStart === 1'b1) begin
            fsCount++;
            fsInterval = cyc - fsLast;
            fsLast = cyc;
            lastAct = actAcc;
            actAcc = 0;
        end else if (vif.activeVideo === 1'b1) begin
            actAcc++;
        end
        if (cyc < 1024) begin
            hHist[cyc]  = vif.hCount;
            vHist[cyc]  = vif.vCount;
            avHist[cyc] = vif.activeVideo;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic driveLine(input int pix, input logic vs);
        vif.hSync = 1'b0;
        vif.vSync = vs;
        repeat (HS << PS) @(negedge Clk);
        vif.hSync = 1'b1;
        repeat ((pix - HS) << PS) @(negedge Clk);
    endtask

    task automatic driveFrame(input int vsLines, input int longIdx, input int extra);
        for (int l = 0; l < VT; l++) begin
            lineStartCyc[l] = cyc;
            driveLine(HT + ((l == longIdx) ? extra : 0), (l < vsLines) ? 1'b0 : 1'b1);
        end
    endtask

    initial begin
        int f2;
        int d0;
        int d2;
        int d;

        vif.hSync = 1'b1;
        vif.vSync = 1'b1;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_hCount", vif.hCount, 0);
        chk("rst_vCount", vif.vCount, 0);
        chk("rst_active", vif.activeVideo, 0);
        chk("rst_frameStart", vif.frameStart, 0);
        chk("rst_locked", vif.locked, 0);
        chk("rst_errCount", vif.errCount, 0);
        Reset = 1'b0;

        // Ideal timing, three frames.
        driveFrame(VS, -1, 0);
        f2 = cyc;
        driveFrame(VS, -1, 0);
        driveFrame(VS, -1, 0);
        d0 = lineStartCyc[0];
        d2 = lineStartCyc[2];
        chk("ideal_lockRise", lockRiseCyc, f2 + 3);
        chk("ideal_locked", vif.locked, 1);
        chk("ideal_errCount", vif.errCount, 0);
        chk("ideal_fsCount", fsCount, 3);
        chk("ideal_fsInterval", fsInterval, FRAME);
        chk("ideal_activePerFrame", lastAct, (HW << PS) * VH);
        chk("ideal_hCountLineEnd", hHist[d0 + 2], HT - 1);
        chk("ideal_vCountFrameEnd", vHist[d0 + 2], VT - 1);
        chk("ideal_hCountZero", hHist[d0 + 3], 0);
        chk("ideal_vCountZero", vHist[d0 + 3], 0);
        chk("ideal_hCountMid", hHist[d0 + 3 + 10], 5);
        chk("ideal_avBeforeWin", avHist[d2 + 8], 0);
        chk("ideal_avFirstPix", avHist[d2 + 9], 1);
        chk("ideal_avLastPix", avHist[d2 + 16], 1);
        chk("ideal_avAfterWin", avHist[d2 + 17], 0);

        // One line a pixel too long while locked.
        driveFrame(VS, 1, 1);
        chk("long_lockFall", lockFallCyc, lineStartCyc[2] + 2);
        chk("long_errCount", vif.errCount, 1);
        chk("long_locked", vif.locked, 0);
        driveFrame(VS, -1, 0);
        f2 = cyc;
        driveFrame(VS, -1, 0);
        chk("long_relockRise", lockRiseCyc, f2 + 3);
        chk("long_relocked", vif.locked, 1);

        // vSync three lines wide.
        driveFrame(3, -1, 0);
        chk("vwide_lockFall", lockFallCyc, lineStartCyc[3] + 2);
        chk("vwide_errCount", vif.errCount, 2);
        chk("vwide_locked", vif.locked, 0);
        driveFrame(VS, -1, 0);
        f2 = cyc;
        driveFrame(VS, -1, 0);
        chk("vwide_relockRise", lockRiseCyc, f2 + 3);

        // hSync stuck high after one normal line.
        chk("stuck_lockedBefore", vif.locked, 1);
        d = cyc;
        driveLine(HT, 1'b1);
        repeat (4200) @(negedge Clk);
        chk("stuck_lockFall", lockFallCyc, d + 4098);
        chk("stuck_errCount", vif.errCount, 3);
        chk("stuck_hCount", vif.hCount, 1023);
        chk("stuck_locked", vif.locked, 0);

        // Recover from the stall, then reset in the middle of the second frame.
        driveFrame(VS, -1, 0);
        f2 = cyc;
        driveLine(HT, 1'b0);
        driveLine(HT, 1'b0);
        driveLine(HT, 1'b1);
        chk("rstmid_lockRise", lockRiseCyc, f2 + 3);
        chk("rstmid_errBefore", vif.errCount, 3);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rstmid_hCount", vif.hCount, 0);
        chk("rstmid_vCount", vif.vCount, 0);
        chk("rstmid_active", vif.activeVideo, 0);
        chk("rstmid_frameStart", vif.frameStart, 0);
        chk("rstmid_locked", vif.locked, 0);
        chk("rstmid_errCount", vif.errCount, 0);
        Reset = 1'b0;
        driveLine(HT, 1'b1);
        driveLine(HT, 1'b1);
        driveFrame(VS, -1, 0);
        f2 = cyc;
        driveFrame(VS, -1, 0);
        chk("rstmid_relockRise", lockRiseCyc, f2 + 3);
        chk("rstmid_errAfter", vif.errCount, 0);

        // 300 lock losses: errCount must stop at 255.
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            driveFrame(VS, -1, 0);
            driveFrame(VS, 0, 1);
            if (i == 9)   chk("sat_errCount10", vif.errCount, 10);
            if (i == 254) chk("sat_errCount255", vif.errCount, 255);
        end
        chk("sat_errCountFinal", vif.errCount, 255);
        chk("sat_locked", vif.locked, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Recovers pixel and line position from the VGA `hSync`/`vSync` pair driven by the display controller, independently of that controller's internal counters. Checks every line and frame against the expected 640x480 @ 60 Hz timing and reports lock status and error counts. It sits beside the VGA output pins on the board top level. Its `locked` output drives a spare LED (`Ld3`), and its recovered counts feed on-chip checkers.

## Interface
- `PIX_SHIFT`, default 2: log2 of Clk cycles per pixel (4 at 100 MHz / 25 MHz)
- `H_TOTAL`, default 800: pixels per line
- `H_SYNC`, default 96: hSync low width, in pixels
- `H_ACT`, default 144: first active pixel, counted from the hSync falling edge
- `V_TOTAL`, default 525: lines per frame
- `V_SYNC`, default 2: vSync low width, in lines
- `V_ACT`, default 35: first active line, counted from the vSync falling edge
- `Clk` input 1: system clock (100 MHz); the only clock
- `Reset` input 1: synchronous, active-high
- `hSync` input 1: horizontal sync, active-low
- `vSync` input 1: vertical sync, active-low
- `hCount` output 10: recovered pixel index; 0 at the start of the hSync pulse
- `vCount` output 10: recovered line index; 0 at the start of the vSync pulse
- `activeVideo` output 1: high inside the 640x480 active window
- `frameStart` output 1: one-cycle pulse on each detected vSync falling edge
- `locked` output 1: timing has been verified for a full frame
- `errCount` output 8: number of lock losses, saturating

## Operation
- **Sync sampling.** Each sync is passed through two flops, `q1` then `q2`. Both flops reset to 1 (idle high), so no edge is seen when reset is released.
  - `hFall` = `hq2 & ~hq1`; `hRise` = `~hq2 & hq1`. `vFall` and `vRise` are formed the same way.
- **Line counter.** `lineClk` is 12 bits.
  - On `hFall` it loads 0. Otherwise it increments, saturating at 4095.
  - `hCount` = `lineClk >> PIX_SHIFT`, taken as 10 bits.
- **Frame counter.** `lineCnt` is 10 bits.
  - On `hFall` it increments; if `vFall` occurs in the same cycle it loads 0 instead.
  - `vCount` = `lineCnt`.
- **Active window.** `activeVideo` = (`H_ACT` <= `hCount` < `H_ACT`+640) and (`V_ACT` <= `vCount` < `V_ACT`+480). It is registered.
- **Line errors.** All comparisons use the value before the update in that cycle.
  - On `hFall`: error if `lineClk`+1 != `H_TOTAL`<<`PIX_SHIFT`.
  - On `hRise`: error if `lineClk`+1 != `H_SYNC`<<`PIX_SHIFT`.
  - On the cycle `lineClk` reaches 4095: one timeout error.
- **Frame errors.**
  - On `vFall`: error if there is no coincident `hFall`, or if `lineCnt`+1 != `V_TOTAL`.
  - On `vRise`: error if there is no coincident `hFall`, or if `lineCnt`+1 != `V_SYNC`.
- **Error flag.** `errSeen` is set by any error and cleared on each `vFall`. The clear takes priority, but an error raised in the `vFall` cycle itself is still evaluated against the frame that is ending.
- **FSM.**
  - SEARCH (the reset state): `vFall` → ACQUIRE.
  - ACQUIRE: on `vFall`, if no error occurred in the frame just ended → LOCKED; otherwise stay in ACQUIRE.
  - LOCKED: any error → SEARCH, and `errCount` increments (saturating at 255).
  - Errors in SEARCH or ACQUIRE never touch `errCount`.
- **Lock output.** `locked` = (state == LOCKED), registered.

## Timing
- **Reset values.** `hCount`=0, `vCount`=0, `activeVideo`=0, `frameStart`=0, `locked`=0, `errCount`=0, state=SEARCH, `lineClk`=0, `lineCnt`=0.
- **Sync latency.** If `hSync` is first sampled low at edge N, `hCount` reads 0 after edge N+2. `vSync` has the same latency to `frameStart` and to `vCount`=0.
- **Frame pulse.** `frameStart` is high for exactly one cycle after each `vFall`.
- **Time to lock.** With ideal input, `locked` rises 2 cycles after the second `vFall` sampled after reset.
- **Time to drop lock.** `locked` falls on the edge after the error cycle. `errCount` updates on the same edge.
- **Reset priority.** `Reset` mid-frame has priority over everything: all outputs return to reset values on the next edge, and lock is re-acquired from scratch.
- **Simultaneous events.** Coincident `hFall`/`vFall` is the normal case and is not an error. Several errors in one cycle count as a single lock loss.

## Test plan
- **Ideal timing, 3 frames.** Drive 800x525, 96/2 sync, 4 clocks per pixel. Required: `locked` is high 2 cycles after the second `vFall`; `errCount`=0; exactly 307200 pixels × 4 Clk of `activeVideo` per frame; `frameStart` fires once per 1,680,000 Clk.
- **Long line while locked.** Insert one 801-pixel line. Required: `locked` drops at that line's `hFall`+1; `errCount`=1; `locked` is regained after the next two frames.
- **Wrong vSync width.** Make vSync 3 lines wide while locked. Required: a frame error on `vRise`; `locked`=0; `errCount` increments.
- **hSync stuck high.** Required: timeout 4096 Clk after the last `hFall`; `locked`=0; `hCount` holds at 1023.
- **Reset in the middle of frame 2.** Required: all outputs 0 on the next edge; no `errCount` increment; relock after two `vFall`s.
- **Repeated errors.** Force 300 lock-loss cycles. Required: `errCount` saturates at 255 and does not wrap.
